// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg -- shared constants and types for the multi-cycle ALU (alu_mc).
//
// Contents:
//   OP_*     4-bit opcode constants driven on alu_mc.ALU_control
//   state_e  FSM state type for alu_mc
//
// Configuration macro: ALU_MUL_EN
//   Defined   -> the S_MUL state exists and opcode OP_MUL runs the multiplier.
//   Undefined -> no S_MUL state; OP_MUL decodes as an undefined opcode.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd2
`ifdef ALU_MUL_EN
    ,
    S_MUL  = 2'd1
`endif
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq -- unsigned shift-add multiplier, one multiplier bit per cycle.
//
// Only instantiated by alu_mc when ALU_MUL_EN is defined.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset; drops any operation in flight
//   start       load a/b and begin a WIDTH-step multiply (ignored result of
//               any previous operation)
//   a, b        multiplicand / multiplier, sampled when start=1
//   done        high during the cycle whose closing edge performs the final
//               step; prod_lo / prod_hi_nz are valid in that cycle only
//   prod_lo     low WIDTH bits of the finished product
//   prod_hi_nz  1 when the high WIDTH bits of the product are nonzero
//
// Timing: start on edge 0, steps on edges 1..WIDTH. done is asserted before
// edge WIDTH so the consumer can capture the final product on that same edge.
// -----------------------------------------------------------------------------
module alu_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic             prod_hi_nz
);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  // Product register: high half accumulates, low half holds the remaining
  // multiplier bits; each step shifts the whole thing right by one.
  logic [2*WIDTH-1:0] prod_q,  prod_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               busy_q,  busy_d;

  logic [WIDTH:0]     partial;
  logic [2*WIDTH-1:0] prod_step;

  always_comb begin
    partial   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
              + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod_step = {partial, prod_q[WIDTH-1:1]};
  end

  assign done       = busy_q & (cnt_q == CNT_W'(WIDTH - 1));
  // Exposes the post-step value so the final step and the capture share an edge.
  assign prod_lo    = prod_step[WIDTH-1:0];
  assign prod_hi_nz = |prod_step[2*WIDTH-1:WIDTH];

  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (start) begin
      mcand_d = a;
      prod_d  = {{WIDTH{1'b0}}, b};
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      prod_d = prod_step;
      cnt_d  = cnt_q + 1'b1;
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc -- multi-cycle ALU with valid/ready handshakes on both sides.
//
// Single-cycle ops (AND, OR, ADD, SUB, SLT, NOR, undefined) are evaluated on
// the offered operands and captured on the accept edge. MUL (only with
// ALU_MUL_EN defined) runs the alu_mul_seq shift-add unit for WIDTH cycles.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   in_valid       operand/opcode offer
//   in_ready       accept this cycle (combinational: IDLE, or DONE being drained)
//   src1, src2     operands A and B
//   ALU_control    opcode, see alu_pkg OP_*
//   out_valid      result/flags valid (state DONE)
//   out_ready      consumer takes the result this cycle
//   result         registered result
//   zero, cout, overflow   registered flags
//
// Configuration macro: ALU_MUL_EN (enables MUL state, multiplier and counter).
// -----------------------------------------------------------------------------
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q,   zero_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;

  logic             accept;

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath on the offered operands
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   add_sum, sub_sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  always_comb begin
    add_sum = {1'b0, src1} + {1'b0, src2};
    sub_sum = {1'b0, src1} + {1'b0, ~src2} + {{WIDTH{1'b0}}, 1'b1};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALU_control)
      OP_AND: alu_res = src1 & src2;
      OP_OR:  alu_res = src1 | src2;
      OP_NOR: alu_res = ~(src1 | src2);
      OP_ADD: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        // Same-sign operands producing a different-sign sum.
        alu_v   = (src1[WIDTH-1] == src2[WIDTH-1])
                & (add_sum[WIDTH-1] != src1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_sum[WIDTH-1:0];
        alu_c   = sub_sum[WIDTH];   // 1 = no borrow
        alu_v   = (src1[WIDTH-1] != src2[WIDTH-1])
                & (sub_sum[WIDTH-1] != src1[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
      // Undefined opcodes (and OP_MUL when the multiplier is compiled out)
      // complete as result 0; zero follows from the result.
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Optional sequential multiplier
  // ---------------------------------------------------------------------------
`ifdef ALU_MUL_EN
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_lo;
  logic             mul_hi_nz;

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk        (clk),
    .rst        (rst),
    .start      (mul_start),
    .a          (src1),
    .b          (src2),
    .done       (mul_done),
    .prod_lo    (mul_lo),
    .prod_hi_nz (mul_hi_nz)
  );
`else
  // CNT_W only sizes the multiplier's step counter.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM; result/flags only move when a new result is produced, so they
  // hold while DONE waits on out_ready.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
`ifdef ALU_MUL_EN
    mul_start = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && out_ready) state_d = S_IDLE;
        if (accept) begin
`ifdef ALU_MUL_EN
          if (ALU_control == OP_MUL) begin
            state_d   = S_MUL;
            mul_start = 1'b1;
          end else
`endif
          begin
            state_d  = S_DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            cout_d   = alu_c;
            ovf_d    = alu_v;
          end
        end
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        if (mul_done) begin
          state_d  = S_DONE;
          result_d = mul_lo;
          zero_d   = (mul_lo == '0);
          cout_d   = mul_hi_nz;
          ovf_d    = 1'b0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal 8..64).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH)+1, meaning the multiply step counter width.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst  input  1  meaning the reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid  input  1  meaning an operand/opcode pair is offered.
REQ-006 The block SHALL have port in_ready  output  1  meaning the block accepts the offer this cycle.
REQ-007 The block SHALL have port src1  input  WIDTH  meaning operand A.
REQ-008 The block SHALL have port src2  input  WIDTH  meaning operand B.
REQ-009 The block SHALL have port ALU_control  input  4  meaning the opcode: 0 AND, 1 OR, 2 ADD, 3 MUL, 6 SUB, 7 SLT, 12 NOR.
REQ-010 The block SHALL have port out_valid  output  1  meaning the result and flags are valid.
REQ-011 The block SHALL have port out_ready  input  1  meaning the consumer takes the result this cycle.
REQ-012 The block SHALL have port result  output  WIDTH  meaning the registered result.
REQ-013 The block SHALL have ports zero, cout and overflow  output  1 each  meaning the registered flags.

Function
REQ-014 The block SHALL accept a transfer on a rising edge when in_valid and in_ready are both 1, and SHALL latch src1, src2 and ALU_control on that edge.
REQ-015 The block SHALL implement FSM states IDLE, MUL and DONE: IDLE->DONE on accepting a non-MUL op; IDLE->MUL on accepting MUL; MUL->DONE after WIDTH steps; DONE->IDLE on out_ready without a new accept; DONE->DONE or DONE->MUL on out_ready with a new accept.
REQ-016 The block SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready), as a combinational path.
REQ-017 The block SHALL drive out_valid = (state==DONE).
REQ-018 Non-MUL ops SHALL reach DONE one edge after acceptance.
REQ-019 MUL SHALL reach DONE WIDTH+1 edges after acceptance.
REQ-020 result, zero, cout and overflow SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 ADD SHALL compute src1+src2 modulo 2^WIDTH, with cout = carry out of the MSB and overflow = signed overflow.
REQ-022 SUB SHALL compute src1+~src2+1, with cout = carry out of the MSB (1 = no borrow) and overflow = signed overflow.
REQ-023 SLT SHALL compare signed: result = 1 if src1<src2, else 0.
REQ-024 AND, OR, NOR and SLT SHALL force cout=0 and overflow=0.
REQ-025 MUL SHALL be unsigned shift-add, 1 bit per cycle, with result = low WIDTH bits of the product, cout = 1 if the high WIDTH bits are nonzero, and overflow = 0.
REQ-026 For every op, zero SHALL equal (result==0).
REQ-027 Undefined opcodes SHALL complete in 1 cycle with result = 0, zcv = 100.
REQ-028 in_valid during MUL SHALL be ignored: no accept, no corruption of the operation in progress.

Reset
REQ-029 When rst=1 on a rising edge, the block SHALL go to IDLE, clear the step counter and set result=0, zero=0, cout=0, overflow=0 and out_valid=0.
REQ-030 rst SHALL take priority over any accept or step, including mid-MUL; the aborted operation SHALL produce no output.
REQ-031 After reset, in_ready SHALL be 1 combinationally while rst=0.

Configuration
REQ-032 With ALU_MUL_EN defined, opcode 3 SHALL perform MUL per REQ-025 and the MUL state SHALL exist.
REQ-033 Without ALU_MUL_EN, opcode 3 SHALL be treated as undefined per REQ-027, and the MUL state, the multiplier instance and the step counter SHALL be absent.

Structure
REQ-034 Package alu_pkg SHALL hold the opcode constants (OP_AND, OP_OR, OP_ADD, OP_MUL, OP_SUB, OP_SLT, OP_NOR) and the FSM state type.
REQ-035 The shift-add datapath SHALL be sub-module alu_mul_seq, parametrised by WIDTH, with start/done handshake, instantiated only under ALU_MUL_EN.

Verification (WIDTH=32, zcv = {zero,cout,overflow})
REQ-036 A bench SHALL show: ADD 0x7FFFFFFF+0x00000001 -> result 0x80000000, zcv 001, out_valid 1 edge after accept.
REQ-037 A bench SHALL show: SUB 5-5 -> 0x00000000, zcv 110; SLT 0xFFFFFFFF vs 0x00000001 -> 0x00000001, zcv 000.
REQ-038 A bench SHALL show: MUL 0x00010000*0x00010000 -> 0x00000000, zcv 110, out_valid 33 edges after accept; without ALU_MUL_EN -> 0x00000000, zcv 100, after 1 edge.
REQ-039 A bench SHALL show: out_ready held 0 for 5 cycles after AND 0xF0F0F0F0&0xFF00FF00 -> result 0xF000F000 held, in_ready 0; raising out_ready with in_valid=1 -> back-to-back accept in the same cycle.
REQ-040 A bench SHALL show: rst pulsed 10 cycles into a MUL -> next edge out_valid 0, flags 0, in_ready 1, and no stale result ever appears.
